// File: rtl/cap_sense_scanner.sv
// Capacitive sensor scanner: discharges a shared charge line, then times each
// sense pin's RC rise and publishes per-sensor charge times plus a touch mask.
module cap_sense_scanner #(
  parameter int N_SENSORS        = 9,
  parameter int CNT_W            = 32,
  parameter int DISCHARGE_CYCLES = 1000,
  parameter int TIMEOUT          = 50000,
  parameter int TOUCH_THRESHOLD  = 2000
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [N_SENSORS-1:0]         sensors_in,
  output logic                         sensors_out,
  output logic [N_SENSORS*CNT_W-1:0]   readings,
  output logic [N_SENSORS-1:0]         touched,
  output logic                         frame_done
);

  localparam int DW = (DISCHARGE_CYCLES > 1) ? $clog2(DISCHARGE_CYCLES) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  // A saturated reading must fit in the published width.
  if ((TIMEOUT < 1) || (64'(TIMEOUT) > ((64'd1 << CNT_W) - 64'd1))) begin : g_bad_timeout
    $error("cap_sense_scanner: TIMEOUT out of range for CNT_W");
  end

  typedef enum logic [1:0] {
    ST_DISCHARGE = 2'd0,
    ST_CHARGE    = 2'd1,
    ST_PUBLISH   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [DW-1:0]          dcnt_q, dcnt_d;
  logic [CW-1:0]          ccnt_q, ccnt_d;
  logic [N_SENSORS-1:0]   sync1_q, s_q;
  logic [N_SENSORS-1:0]   flag_q, flag_d;
  logic [CW-1:0]          cap_q [N_SENSORS];
  logic [CW-1:0]          cap_d [N_SENSORS];
  logic [CNT_W-1:0]       readings_q [N_SENSORS];
  logic [CNT_W-1:0]       readings_d [N_SENSORS];
  logic [N_SENSORS-1:0]   touched_q, touched_d;
  logic                   sensors_out_q, sensors_out_d;
  logic                   frame_done_q, frame_done_d;

  always_comb begin
    state_d    = state_q;
    dcnt_d     = dcnt_q;
    ccnt_d     = ccnt_q;
    flag_d     = flag_q;
    cap_d      = cap_q;
    readings_d = readings_q;
    touched_d  = touched_q;

    case (state_q)
      ST_DISCHARGE: begin
        if (dcnt_q == DW'(DISCHARGE_CYCLES - 1)) begin
          state_d = ST_CHARGE;
          dcnt_d  = '0;
          ccnt_d  = '0;
          flag_d  = '0;
        end else begin
          dcnt_d = dcnt_q + 1'b1;
        end
      end
      ST_CHARGE: begin
        ccnt_d = ccnt_q + 1'b1;
        for (int i = 0; i < N_SENSORS; i++) begin
          if (s_q[i] && !flag_q[i]) begin
            cap_d[i]  = ccnt_q;
            flag_d[i] = 1'b1;
          end
        end
        // Captures above take priority over the saturation value below.
        if (&flag_d) begin
          state_d = ST_PUBLISH;
        end else if (ccnt_q == CW'(TIMEOUT - 1)) begin
          for (int i = 0; i < N_SENSORS; i++) begin
            if (!flag_d[i]) begin
              cap_d[i] = CW'(TIMEOUT);
            end
          end
          flag_d  = '1;
          state_d = ST_PUBLISH;
        end
      end
      ST_PUBLISH: begin
        state_d = ST_DISCHARGE;
        dcnt_d  = '0;
      end
      default: begin
        state_d = ST_DISCHARGE;
        dcnt_d  = '0;
      end
    endcase

    // Outputs are registered from the next state so they align with it.
    sensors_out_d = (state_d == ST_CHARGE);
    frame_done_d  = (state_d == ST_PUBLISH);
    if (state_d == ST_PUBLISH) begin
      for (int i = 0; i < N_SENSORS; i++) begin
        readings_d[i] = CNT_W'(cap_d[i]);
        touched_d[i]  = (64'(cap_d[i]) > 64'(TOUCH_THRESHOLD));
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= ST_DISCHARGE;
      dcnt_q        <= '0;
      ccnt_q        <= '0;
      sync1_q       <= '0;
      s_q           <= '0;
      flag_q        <= '0;
      cap_q         <= '{default: '0};
      readings_q    <= '{default: '0};
      touched_q     <= '0;
      sensors_out_q <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      dcnt_q        <= dcnt_d;
      ccnt_q        <= ccnt_d;
      sync1_q       <= sensors_in;
      s_q           <= sync1_q;
      flag_q        <= flag_d;
      cap_q         <= cap_d;
      readings_q    <= readings_d;
      touched_q     <= touched_d;
      sensors_out_q <= sensors_out_d;
      frame_done_q  <= frame_done_d;
    end
  end

  for (genvar gi = 0; gi < N_SENSORS; gi++) begin : g_pack
    assign readings[CNT_W*gi +: CNT_W] = readings_q[gi];
  end

  assign sensors_out = sensors_out_q;
  assign touched     = touched_q;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_cap_sense_scanner.sv
// Directed bench for cap_sense_scanner: an RC pin model drives the sense inputs
// and a scoreboard of expected frames is checked on every frame_done.
module tb_cap_sense_scanner;

  localparam int N = 9;
  localparam int W = 32;

  typedef struct packed {
    logic [N*W-1:0] rd;
    logic [N-1:0]   tch;
  } exp_t;

  logic             clock = 1'b0;
  logic             reset = 1'b0;
  logic [N-1:0]     sensors_in = '0;
  logic             sensors_out;
  logic [N*W-1:0]   readings;
  logic [N-1:0]     touched;
  logic             frame_done;

  int errors = 0;
  int checks = 0;

  // Pin model configuration: dly[i] < 0 means the pin never charges.
  int  dly [N];
  bit  all_high = 1'b0;
  bit  glitch0  = 1'b0;
  int  k = 0;
  bit  prev_out = 1'b0;

  exp_t             sb [$];
  logic [N*W-1:0]   last_pub = '0;
  time              last_frame_t = 0;
  int               charge_len, period;
  bit               got;

  cap_sense_scanner dut (
    .clock       (clock),
    .reset       (reset),
    .sensors_in  (sensors_in),
    .sensors_out (sensors_out),
    .readings    (readings),
    .touched     (touched),
    .frame_done  (frame_done)
  );

  always #5 clock = ~clock;

  // k = clocks since sensors_out rose; a pin rises k=dly clocks after that.
  always @(posedge clock) begin
    #1;
    if (sensors_out) k = prev_out ? k + 1 : 0;
    prev_out = sensors_out;
    for (int i = 0; i < N; i++) begin
      if (all_high)            sensors_in[i] = 1'b1;
      else if (!sensors_out)   sensors_in[i] = 1'b0;
      else if (i == 0 && glitch0) sensors_in[i] = (k == 10) || (k >= 300);
      else                     sensors_in[i] = (dly[i] >= 0) && (k >= dly[i]);
    end
  end

  function automatic exp_t model();
    exp_t e;
    int v;
    for (int i = 0; i < N; i++) begin
      if (all_high)               v = 0;
      else if (i == 0 && glitch0) v = 12;
      else if (dly[i] < 0)        v = 50000;
      else                        v = dly[i] + 2;
      e.rd[W*i +: W] = v;
      e.tch[i]       = (v > 2000);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [N*W-1:0] obs, input logic [N*W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Waits for frame_done, pops the expected frame and compares it.
  task automatic wait_frame(input string tag, input int budget);
    exp_t e;
    bit   hold_ok;
    int   n;
    hold_ok    = 1'b1;
    got        = 1'b0;
    charge_len = 0;
    n          = 0;
    while (n < budget && !got) begin
      @(posedge clock); #1;
      n++;
      if (frame_done) got = 1'b1;
      else begin
        if (sensors_out) charge_len++;
        if (readings !== last_pub) hold_ok = 1'b0;
      end
    end
    chk({tag, " frame_seen"}, got, 1'b1);
    if (!got) return;
    period       = int'(($time - last_frame_t) / 10);
    last_frame_t = $time;
    chk({tag, " hold"}, hold_ok, 1'b1);
    if (sb.size() == 0) begin
      chk({tag, " sb_nonempty"}, 0, 1);
      return;
    end
    e = sb.pop_front();
    for (int i = 0; i < N; i++)
      chk($sformatf("%s rd[%0d]", tag, i), readings[W*i +: W], e.rd[W*i +: W]);
    chk({tag, " touched"}, touched, e.tch);
    $display("frame %s: readings=%0h touched=%b charge=%0d period=%0d",
             tag, readings, touched, charge_len, period);
    last_pub = readings;
    @(posedge clock); #1;
    chk({tag, " pulse_1cyc"}, frame_done, 1'b0);
  endtask

  initial begin
    int n;
    for (int i = 0; i < N; i++) dly[i] = 100 * (i + 1);

    // T1: reset held low
    repeat (3) @(posedge clock);
    #1;
    chk("T1 readings", readings, '0);
    chk("T1 touched", touched, '0);
    chk("T1 sensors_out", sensors_out, 1'b0);
    chk("T1 frame_done", frame_done, 1'b0);
    reset = 1'b1;
    last_frame_t = $time;

    // T2: staggered rise times
    sb.push_back(model());
    wait_frame("T2", 5000);
    chk("T2 charge_len", charge_len, 903);

    // T3: sensor 4 never charges
    for (int i = 0; i < N; i++) dly[i] = 50;
    dly[4] = -1;
    sb.push_back(model());
    wait_frame("T3", 60000);
    chk("T3 charge_len", charge_len, 50000);

    // T4: all pins stuck high
    all_high = 1'b1;
    sb.push_back(model());
    wait_frame("T4a", 3000);
    sb.push_back(model());
    wait_frame("T4b", 3000);
    chk("T4 charge_len", charge_len, 1);
    chk("T4 period", period, 1002);

    // T5: reset mid-charge after a valid frame
    all_high = 1'b0;
    for (int i = 0; i < N; i++) dly[i] = 100 * (i + 1);
    sb.push_back(model());
    wait_frame("T5a", 5000);
    n = 0;
    while (n < 3000 && !sensors_out) begin
      @(posedge clock); #1; n++;
    end
    chk("T5 charge_seen", sensors_out, 1'b1);
    repeat (20) @(posedge clock);
    #1;
    reset = 1'b0;
    @(posedge clock); #1;
    chk("T5 readings_clr", readings, '0);
    chk("T5 touched_clr", touched, '0);
    chk("T5 sensors_out_clr", sensors_out, 1'b0);
    reset    = 1'b1;
    last_pub = '0;
    n = 1;
    while (n < 3000) begin
      @(posedge clock); #1;
      if (sensors_out) break;
      n++;
    end
    chk("T5 discharge_len", n, 1000);
    sb.push_back(model());
    wait_frame("T5b", 5000);

    // T6: one-clock glitch on sensor 0 at 10, real rise at 300
    glitch0 = 1'b1;
    for (int i = 1; i < N; i++) dly[i] = 50;
    sb.push_back(model());
    wait_frame("T6", 5000);

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
